// File: rtl/comma_aligner_if.sv
`timescale 1ns/1ps
// Bundle between the deserializer/sync FSM side and the comma aligner.
// The master side supplies raw words and sync status and receives aligned code-groups.
interface comma_aligner_if #(
  parameter int CG_WIDTH = 10
);
  logic                rx_valid;
  logic [CG_WIDTH-1:0] rx_word;
  logic                code_sync_status;
  logic [CG_WIDTH-1:0] pudi;
  logic                indicate;
  logic [3:0]          align_offset;
  logic                aligned;
  logic [7:0]          realign_cnt;

  modport master (
    output rx_valid, rx_word, code_sync_status,
    input  pudi, indicate, align_offset, aligned, realign_cnt
  );

  modport slave (
    input  rx_valid, rx_word, code_sync_status,
    output pudi, indicate, align_offset, aligned, realign_cnt
  );
endinterface

// File: rtl/comma_aligner.sv
`timescale 1ns/1ps
// 1000BASE-X receive word aligner: hunts all ten bit offsets for a comma,
// locks after repeated hits, and re-hunts on sync loss or sync timeout.
module comma_aligner #(
  parameter int CG_WIDTH     = 10,
  parameter int LOCK_COMMAS  = 3,
  parameter int SYNC_TIMEOUT = 255
) (
  input logic            clk,
  input logic            mr_main_reset_n,
  comma_aligner_if.slave bus
);
  typedef enum logic [1:0] {HUNT, CONFIRM, LOCKED} state_e;

  localparam logic [3:0] LOCK_N       = 4'(LOCK_COMMAS);
  localparam logic [7:0] TIMEOUT_LAST = 8'(SYNC_TIMEOUT - 1);
  localparam logic [7:0] MISS_LAST    = 8'd63;

  state_e              state_q, state_d;
  logic [CG_WIDTH-1:0] prev_word_q, prev_word_d;
  logic                primed_q, primed_d;
  logic [3:0]          hit_cnt_q, hit_cnt_d;
  logic [3:0]          cand_off_q, cand_off_d;
  logic [7:0]          wait_cnt_q, wait_cnt_d;
  logic [3:0]          align_offset_q, align_offset_d;
  logic                sync_seen_q, sync_seen_d;
  logic                sync_prev_q, sync_prev_d;
  logic [7:0]          realign_cnt_q, realign_cnt_d;
  logic [CG_WIDTH-1:0] pudi_q, pudi_d;
  logic                indicate_q, indicate_d;

  logic [2*CG_WIDTH-1:0] window;
  logic [CG_WIDTH-1:0]   cand [CG_WIDTH];
  logic [CG_WIDTH-1:0]   hit_vec;
  logic [CG_WIDTH-1:0]   aligned_word;
  logic [3:0]            low_off;
  logic                  any_hit, cand_hit;
  logic                  word_ok, sync_fall, lost;

  // Candidate k starts k bits into the oldest word of the two-word window.
  always_comb begin
    window       = {prev_word_q, bus.rx_word};
    hit_vec      = '0;
    low_off      = '0;
    cand_hit     = 1'b0;
    aligned_word = '0;
    for (int k = 0; k < CG_WIDTH; k++) begin
      cand[k]    = window[2*CG_WIDTH-1-k -: CG_WIDTH];
      hit_vec[k] = (cand[k][CG_WIDTH-1 -: 7] == 7'b0011111) ||
                   (cand[k][CG_WIDTH-1 -: 7] == 7'b1100000);
      if (cand_off_q == 4'(k))     cand_hit     = hit_vec[k];
      if (align_offset_q == 4'(k)) aligned_word = cand[k];
    end
    for (int k = CG_WIDTH - 1; k >= 0; k--) begin
      if (hit_vec[k]) low_off = 4'(k);
    end
    any_hit = |hit_vec;
  end

  always_comb begin
    // NOTE: every *_d gets its hold value first, so no branch can infer a latch.
    state_d        = state_q;
    prev_word_d    = prev_word_q;
    primed_d       = primed_q;
    hit_cnt_d      = hit_cnt_q;
    cand_off_d     = cand_off_q;
    wait_cnt_d     = wait_cnt_q;
    align_offset_d = align_offset_q;
    sync_seen_d    = sync_seen_q;
    sync_prev_d    = bus.code_sync_status;
    realign_cnt_d  = realign_cnt_q;
    pudi_d         = pudi_q;
    indicate_d     = 1'b0;
    lost           = 1'b0;
    word_ok        = bus.rx_valid && primed_q;
    sync_fall      = sync_prev_q && !bus.code_sync_status;

    if (bus.rx_valid) begin
      prev_word_d = bus.rx_word;
      primed_d    = 1'b1;
    end
    // The locking word itself still leaves at the old offset.
    if (word_ok) begin
      pudi_d     = aligned_word;
      indicate_d = 1'b1;
    end

    unique case (state_q)
      HUNT: begin
        if (word_ok && any_hit) begin
          cand_off_d = low_off;
          hit_cnt_d  = 4'd1;
          wait_cnt_d = '0;
          if (LOCK_N == 4'd1) begin
            state_d        = LOCKED;
            align_offset_d = low_off;
            sync_seen_d    = 1'b0;
          end else begin
            state_d = CONFIRM;
          end
        end
      end
      CONFIRM: begin
        if (word_ok) begin
          if (cand_hit) begin
            hit_cnt_d  = hit_cnt_q + 4'd1;
            wait_cnt_d = '0;
            if (hit_cnt_q + 4'd1 == LOCK_N) begin
              state_d        = LOCKED;
              align_offset_d = cand_off_q;
              sync_seen_d    = 1'b0;
            end
          end else if (any_hit) begin
            cand_off_d = low_off;
            hit_cnt_d  = 4'd1;
            wait_cnt_d = '0;
          end else if (wait_cnt_q == MISS_LAST) begin
            state_d    = HUNT;
            wait_cnt_d = '0;
          end else begin
            wait_cnt_d = wait_cnt_q + 8'd1;
          end
        end
      end
      LOCKED: begin
        if (bus.code_sync_status) sync_seen_d = 1'b1;
        if (word_ok && !sync_seen_q && !bus.code_sync_status) begin
          wait_cnt_d = wait_cnt_q + 8'd1;
          if (wait_cnt_q == TIMEOUT_LAST) lost = 1'b1;
        end
        if (sync_fall) lost = 1'b1;
        // A fall and a timeout together still count as a single loss.
        if (lost) begin
          state_d = HUNT;
          if (realign_cnt_q != 8'hFF) realign_cnt_d = realign_cnt_q + 8'd1;
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge clk or negedge mr_main_reset_n) begin
    if (!mr_main_reset_n) begin
      state_q        <= HUNT;
      prev_word_q    <= '0;
      primed_q       <= 1'b0;
      hit_cnt_q      <= '0;
      cand_off_q     <= '0;
      wait_cnt_q     <= '0;
      align_offset_q <= '0;
      sync_seen_q    <= 1'b0;
      sync_prev_q    <= 1'b0;
      realign_cnt_q  <= '0;
      pudi_q         <= '0;
      indicate_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every flop samples the pre-edge values.
      state_q        <= state_d;
      prev_word_q    <= prev_word_d;
      primed_q       <= primed_d;
      hit_cnt_q      <= hit_cnt_d;
      cand_off_q     <= cand_off_d;
      wait_cnt_q     <= wait_cnt_d;
      align_offset_q <= align_offset_d;
      sync_seen_q    <= sync_seen_d;
      sync_prev_q    <= sync_prev_d;
      realign_cnt_q  <= realign_cnt_d;
      pudi_q         <= pudi_d;
      indicate_q     <= indicate_d;
    end
  end

  assign bus.pudi         = pudi_q;
  assign bus.indicate     = indicate_q;
  assign bus.align_offset = align_offset_q;
  assign bus.aligned      = (state_q == LOCKED);
  assign bus.realign_cnt  = realign_cnt_q;
endmodule

// File: tb/tb_comma_aligner.sv
`timescale 1ns/1ps
// Self-checking bench for comma_aligner: directed alignment scenarios plus a
// randomized phase, all scored against a bit-stream level reference model.
module tb_comma_aligner;
  localparam int LOCK_COMMAS  = 3;
  localparam int SYNC_TIMEOUT = 8;
  localparam logic [9:0] K28_5 = 10'b0011111010;
  localparam logic [9:0] D16_2 = 10'b1001000101;

  typedef struct {
    logic [9:0] pudi;
    logic       aligned;
    logic [3:0] off;
    logic [7:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  comma_aligner_if #(.CG_WIDTH(10)) bus();

  comma_aligner #(
    .CG_WIDTH    (10),
    .LOCK_COMMAS (LOCK_COMMAS),
    .SYNC_TIMEOUT(SYNC_TIMEOUT)
  ) dut (
    .clk            (clk),
    .mr_main_reset_n(rst_n),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  exp_t sb_q[$];
  bit   line_q[$];

  // Reference model state: a candidate offset of -1 means no comma is being tracked.
  bit         m_primed, m_locked, m_seen, m_sync_prev;
  logic [9:0] m_prev;
  int         m_cand, m_hits, m_misses, m_words, m_offset, m_losses;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] cand_at(input logic [19:0] w, input int k);
    return 10'(w >> (10 - k));
  endfunction

  function automatic bit is_comma(input logic [9:0] c);
    return (c[9:3] == 7'b0011111) || (c[9:3] == 7'b1100000);
  endfunction

  function automatic int lowest_comma(input logic [19:0] w);
    for (int k = 0; k < 10; k++) if (is_comma(cand_at(w, k))) return k;
    return -1;
  endfunction

  task automatic model_reset();
    m_primed = 0; m_locked = 0; m_seen = 0; m_sync_prev = 0; m_prev = '0;
    m_cand = -1; m_hits = 0; m_misses = 0; m_words = 0; m_offset = 0; m_losses = 0;
  endtask

  task automatic model_step(input bit v, input logic [9:0] w, input bit s);
    logic [19:0] win;
    int  k, old_off;
    bit  lost, seen_now;
    win     = {m_prev, w};
    old_off = m_offset;
    lost    = 0;
    if (m_locked) begin
      seen_now = m_seen || s;
      if (v && m_primed && !seen_now) begin
        m_words++;
        if (m_words == SYNC_TIMEOUT) lost = 1;
      end
      if (m_sync_prev && !s) lost = 1;
      m_seen = seen_now;
      if (lost) begin
        m_locked = 0;
        m_cand   = -1;
        if (m_losses < 255) m_losses++;
      end
    end else if (v && m_primed) begin
      k = lowest_comma(win);
      if (m_cand < 0) begin
        if (k >= 0) begin m_cand = k; m_hits = 1; m_misses = 0; end
      end else if (is_comma(cand_at(win, m_cand))) begin
        m_hits++; m_misses = 0;
      end else if (k >= 0) begin
        m_cand = k; m_hits = 1; m_misses = 0;
      end else begin
        m_misses++;
        if (m_misses == 64) m_cand = -1;
      end
      if (m_cand >= 0 && m_hits == LOCK_COMMAS) begin
        m_offset = m_cand; m_locked = 1; m_cand = -1; m_words = 0; m_seen = 0;
      end
    end
    m_sync_prev = s;
    if (v && m_primed)
      sb_q.push_back('{cand_at(win, old_off), m_locked, 4'(m_offset), 8'(m_losses)});
    if (v) begin
      m_prev   = w;
      m_primed = 1;
    end
  endtask

  // Serial line of alternating K28.5 / D16.2 code-groups, first bit sent = bit 9.
  task automatic refill();
    logic [9:0] k_cg, d_cg;
    k_cg = K28_5;
    d_cg = D16_2;
    while (line_q.size() < 20) begin
      for (int i = 9; i >= 0; i--) line_q.push_back(k_cg[i]);
      for (int i = 9; i >= 0; i--) line_q.push_back(d_cg[i]);
    end
  endtask

  task automatic slip(input int n);
    refill();
    repeat (n) void'(line_q.pop_front());
  endtask

  task automatic next_word(output logic [9:0] w);
    refill();
    for (int i = 9; i >= 0; i--) w[i] = line_q.pop_front();
  endtask

  task automatic cycle(input bit v, input logic [9:0] w, input bit s);
    bus.rx_valid         = v;
    bus.rx_word          = w;
    bus.code_sync_status = s;
    model_step(v, w, s);
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [9:0] w, input bit s, input int gap);
    repeat (gap) cycle(1'b0, 10'($urandom), s);
    cycle(1'b1, w, s);
  endtask

  task automatic send_stream(input bit s, input int gap);
    logic [9:0] w;
    next_word(w);
    send(w, s, gap);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    bus.rx_valid = 1'b0;
    bus.code_sync_status = 1'b0;
    #1;
    check("rst_pudi", bus.pudi, 0);
    check("rst_indicate", bus.indicate, 0);
    check("rst_align_offset", bus.align_offset, 0);
    check("rst_aligned", bus.aligned, 0);
    check("rst_realign_cnt", bus.realign_cnt, 0);
    model_reset();
    sb_q.delete();
    line_q.delete();
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: every DUT indicate consumes one expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.indicate) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_indicate", 1, 0);
      end else begin
        e = sb_q.pop_front();
        check("sb_pudi", bus.pudi, e.pudi);
        check("sb_aligned", bus.aligned, e.aligned);
        check("sb_align_offset", bus.align_offset, e.off);
        check("sb_realign_cnt", bus.realign_cnt, e.cnt);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  logic       rs;
  bit         rv, got_lock;
  logic [9:0] rw;

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_word = '0;
    bus.code_sync_status = 1'b0;
    model_reset();
    do_reset();

    // Lock at offset 3: commas on every even post-prime word.
    slip(7);
    send_stream(0, 0);
    check("prime_no_indicate", bus.indicate, 0);
    send_stream(0, 0);
    check("first_indicate", bus.indicate, 1);
    repeat (3) send_stream(0, 0);
    check("two_commas_not_locked", bus.aligned, 0);
    repeat (2) send_stream(0, 0);
    check("lock3_aligned", bus.aligned, 1);
    check("lock3_offset", bus.align_offset, 3);

    // Sync timeout with 4-cycle gaps between valid words.
    send_stream(0, 4);
    send_stream(0, 4);
    check("lock3_pudi_k28_5", bus.pudi, K28_5);
    repeat (5) send_stream(0, 4);
    check("timeout_not_yet", bus.aligned, 1);
    send_stream(0, 4);
    check("timeout_aligned", bus.aligned, 0);
    check("timeout_realign_cnt", bus.realign_cnt, 1);
    check("timeout_offset_kept", bus.align_offset, 3);

    // Two commas at offset 3, then the line slips so commas land at offset 7.
    repeat (4) send_stream(0, 0);
    check("hunt3_not_locked", bus.aligned, 0);
    slip(6);
    repeat (5) send_stream(0, 0);
    check("restart_not_locked", bus.aligned, 0);
    repeat (2) send_stream(0, 0);
    check("lock7_aligned", bus.aligned, 1);
    check("lock7_offset", bus.align_offset, 7);

    // Sync loss by falling edge on idle cycles.
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b1);
    check("sync_high_still_locked", bus.aligned, 1);
    cycle(1'b0, '0, 1'b0);
    check("syncloss_aligned", bus.aligned, 0);
    check("syncloss_realign_cnt", bus.realign_cnt, 2);
    check("syncloss_offset_kept", bus.align_offset, 7);

    // Randomized traffic: stream words, junk words, slips, gaps, sync toggles.
    rs = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      rv = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 40) == 0) slip($urandom_range(1, 9));
      if ($urandom_range(0, 3) == 0) rw = 10'($urandom);
      else next_word(rw);
      if ($urandom_range(0, 15) == 0) rs = ~rs;
      cycle(rv, rw, rs);
    end
    cycle(1'b0, '0, 1'b0);

    // Saturation: repeated lock followed by a sync fall.
    for (int i = 0; i < 260; i++) begin
      got_lock = 0;
      for (int j = 0; j < 40 && !got_lock; j++) begin
        send_stream(0, 0);
        got_lock = bus.aligned;
      end
      if (!got_lock) begin
        check("sat_lock_bound", 0, 1);
        break;
      end
      cycle(1'b0, '0, 1'b1);
      cycle(1'b0, '0, 1'b0);
    end
    check("realign_saturated", bus.realign_cnt, 255);

    // Reset mid-stream clears everything; priming repeats after release.
    send_stream(0, 0);
    do_reset();
    slip(3);
    send_stream(0, 0);
    check("reprime_no_indicate", bus.indicate, 0);
    send_stream(0, 0);
    check("reprime_indicate", bus.indicate, 1);

    // 63 misses in CONFIRM keep the candidate alive.
    do_reset();
    send(10'h155, 0, 0);
    send(10'h151, 0, 0);
    send(10'h3D5, 0, 0);
    repeat (62) send(10'h155, 0, 0);
    send(10'h151, 0, 0);
    send(10'h3D5, 0, 0);
    send(10'h151, 0, 0);
    send(10'h3D5, 0, 0);
    check("miss63_locked", bus.aligned, 1);
    check("miss63_offset", bus.align_offset, 7);

    // 64 misses in CONFIRM drop back to HUNT, so two more commas do not lock.
    do_reset();
    send(10'h155, 0, 0);
    send(10'h151, 0, 0);
    send(10'h3D5, 0, 0);
    repeat (63) send(10'h155, 0, 0);
    send(10'h151, 0, 0);
    send(10'h3D5, 0, 0);
    send(10'h151, 0, 0);
    send(10'h3D5, 0, 0);
    check("miss64_rehunt", bus.aligned, 0);

    @(negedge clk);
    #1;
    check("sb_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
